// File: rtl/xbar_route_arbiter.sv
// Round-robin route arbiter for a single-path blocking crossbar: grants one input,
// issues its control word, then holds the path until the packet's beats have fired.
module xbar_route_arbiter #(
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int LEN_WIDTH         = 8,
    localparam int NI_W             = $clog2(N_INPUTS),
    localparam int NO_W             = $clog2(N_OUTPUTS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_INPUTS-1:0]                 req_val,
    input  logic [N_INPUTS-1:0][NO_W-1:0]       req_dest,
    input  logic [N_INPUTS-1:0][LEN_WIDTH-1:0]  req_len,
    output logic [N_INPUTS-1:0]                 req_rdy,
    output logic [CONTROL_BIT_WIDTH-1:0]        control,
    output logic                                control_val,
    input  logic                                control_rdy,
    input  logic                                xfer_fire,
    output logic                                busy,
    output logic [NI_W-1:0]                     active_input
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

    localparam logic [NI_W:0] NI_N = (NI_W+1)'(N_INPUTS);

    state_t                 r_state, w_next;
    logic [NI_W-1:0]        r_rr_ptr;
    logic [NI_W-1:0]        r_active;
    logic [NO_W-1:0]        r_dest;
    logic [LEN_WIDTH-1:0]   r_count;

    logic                   w_found;
    logic [NI_W-1:0]        w_winner;
    logic [NI_W:0]          w_sum;
    logic [NI_W-1:0]        w_idx;
    logic                   w_last_beat;

    function automatic logic [NI_W-1:0] inc_mod(input logic [NI_W-1:0] x);
        return (x == NI_W'(N_INPUTS-1)) ? '0 : x + NI_W'(1);
    endfunction

    // Round-robin search starting at r_rr_ptr; first requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (NI_W+1)'(k);
            w_idx = NI_W'((w_sum >= NI_N) ? w_sum - NI_N : w_sum);
            if (!w_found && req_val[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_last_beat = xfer_fire && (r_count == LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found && (req_len[w_winner] != '0)) w_next = ISSUE;
            ISSUE:   if (control_rdy) w_next = XFER;
            XFER:    if (w_last_beat) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant bookkeeping; the pointer only advances once a grant has fully completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_active <= '0;
            r_dest   <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_active <= w_winner;
                    r_dest   <= req_dest[w_winner];
                    r_count  <= req_len[w_winner];
                    if (req_len[w_winner] == '0) r_rr_ptr <= inc_mod(w_winner);
                end
                XFER: if (xfer_fire) begin
                    r_count <= r_count - LEN_WIDTH'(1);
                    if (w_last_beat) r_rr_ptr <= inc_mod(r_active);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_rdy = '0;
        if (r_state == IDLE && w_found) req_rdy[w_winner] = 1'b1;
    end

    always_comb begin
        control = '0;
        control[CONTROL_BIT_WIDTH-1 -: NI_W]      = r_active;
        control[CONTROL_BIT_WIDTH-NI_W-1 -: NO_W] = r_dest;
    end

    assign control_val  = (r_state == ISSUE);
    assign busy         = (r_state != IDLE);
    assign active_input = r_active;

endmodule
